// File: rtl/bus_pkg.sv
// ============================================================================
// Module : bus_pkg
// Brief  : Shared types for the cpu_core byte-bus memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  // Select code as seen on {cpu_bus_pc, cpu_bus_mar, cpu_bus_mdr}.
  typedef enum logic [2:0] {
    SEL_NONE  = 3'b000,
    SEL_WRITE = 3'b001,
    SEL_READ  = 3'b010,
    SEL_FETCH = 3'b100
  } bus_sel_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_WRITE   = 3'd4,
    S_READ    = 3'd5,
    S_TX_LO   = 3'd6,
    S_TX_HI   = 3'd7
  } resp_state_t;

  function automatic logic sel_is_onehot(input logic [2:0] s);
    return (s == SEL_WRITE) || (s == SEL_READ) || (s == SEL_FETCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/resp_mem.sv
// ============================================================================
// Module : resp_mem
// Brief  : Single-port synchronous RAM, MEM_WORDS x 16, one-cycle read latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module resp_mem #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [MEM_WORDS];
  logic [15:0] rdata_q;

  // Contents are deliberately left uninitialised; reset does not clear memory.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bus_mem_responder.sv
// ============================================================================
// Module : bus_mem_responder
// Brief  : Memory-side responder for the cpu_core 8-bit byte bus.
//          Optional macro RESP_TIMEOUT_EN enables the response-timeout abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int MEM_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_out_bus,
  input  logic       cpu_bus_pc,
  input  logic       cpu_bus_mar,
  input  logic       cpu_bus_mdr,
  input  logic       cpu_byte_taken,
  input  logic       cpu_halt,
  output logic       rx_ready,
  output logic       data_ready,
  output logic [7:0] rsp_byte,
  output logic       proto_err,
  output logic       timeout
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  resp_state_t   state_q, state_d;
  bus_sel_t      sel_q, sel_d;
  logic [7:0]    addr_lo_q, addr_lo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          proto_err_q, proto_err_d;
  logic          halt_q;

  logic [2:0]    w_sel;
  logic          w_rx_state;
  logic          w_tx_state;
  logic          w_take;
  logic          w_tmo_hit;
  logic          w_mem_we;
  logic          w_mem_re;
  logic [15:0]   w_mem_rdata;

  assign w_sel      = {cpu_bus_pc, cpu_bus_mar, cpu_bus_mdr};
  assign w_rx_state = state_q inside {S_IDLE, S_ADDR_HI, S_DATA_LO, S_DATA_HI};
  assign w_tx_state = state_q inside {S_TX_LO, S_TX_HI};

  // Halt is registered so the handshake outputs never see a comb path from inputs.
  assign rx_ready   = w_rx_state & ~halt_q;
  assign data_ready = w_tx_state & ~halt_q;
  assign proto_err  = proto_err_q;
  assign w_take     = data_ready & cpu_byte_taken;

  always_comb begin
    rsp_byte = 8'h00;
    case (state_q)
      S_TX_LO: rsp_byte = w_mem_rdata[7:0];
      S_TX_HI: rsp_byte = w_mem_rdata[15:8];
      default: rsp_byte = 8'h00;
    endcase
  end

  assign w_mem_re = (state_q == S_READ);
  assign w_mem_we = (state_q == S_WRITE) & ~cpu_halt & ~rst;

  resp_mem #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_mem_we),
    .re_i    (w_mem_re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (w_mem_rdata)
  );

`ifdef RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q;

  assign w_tmo_hit = data_ready & ~cpu_byte_taken &
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_READ || w_take) begin
      tmo_cnt_d = '0;
    end else if (data_ready && !cpu_byte_taken) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (w_tmo_hit && !cpu_halt) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_lo_d   = addr_lo_q;
    addr_d      = addr_q;
    data_d      = data_q;
    proto_err_d = proto_err_q;

    if (cpu_halt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_ready && w_sel != SEL_NONE) begin
            if (sel_is_onehot(w_sel)) begin
              sel_d     = bus_sel_t'(w_sel);
              addr_lo_d = cpu_out_bus;
              state_d   = S_ADDR_HI;
            end else begin
              proto_err_d = 1'b1;
            end
          end
        end
        S_ADDR_HI, S_DATA_LO, S_DATA_HI: begin
          // A select that differs from the latched code covers multi-hot too.
          if (rx_ready && w_sel != SEL_NONE) begin
            if (w_sel == sel_q) begin
              case (state_q)
                S_ADDR_HI: begin
                  addr_d  = AW'({cpu_out_bus, addr_lo_q});
                  state_d = (sel_q == SEL_WRITE) ? S_DATA_LO : S_READ;
                end
                S_DATA_LO: begin
                  data_d[7:0] = cpu_out_bus;
                  state_d     = S_DATA_HI;
                end
                default: begin
                  data_d[15:8] = cpu_out_bus;
                  state_d      = S_WRITE;
                end
              endcase
            end else begin
              proto_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        S_WRITE: state_d = S_IDLE;
        S_READ:  state_d = S_TX_LO;
        S_TX_LO: begin
          if (w_take) begin
            state_d = S_TX_HI;
          end else if (w_tmo_hit) begin
            state_d = S_IDLE;
          end
        end
        S_TX_HI: begin
          if (w_take || w_tmo_hit) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_NONE;
      addr_lo_q   <= 8'h00;
      addr_q      <= '0;
      data_q      <= 16'h0000;
      proto_err_q <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_lo_q   <= addr_lo_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      proto_err_q <= proto_err_d;
      halt_q      <= cpu_halt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
// ============================================================================
// Module : tb_bus_mem_responder
// Brief  : Directed self-checking bench for bus_mem_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_mem_responder;

  logic       clk;
  logic       rst;
  logic [7:0] bus;
  logic [2:0] sel;
  logic       taken;
  logic       halt;
  logic       rx_ready;
  logic       data_ready;
  logic [7:0] rsp_byte;
  logic       proto_err;
  logic       timeout;

  int n_cmp = 0;
  int n_mis = 0;

  bus_mem_responder #(
    .MEM_WORDS      (256),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_out_bus    (bus),
    .cpu_bus_pc     (sel[2]),
    .cpu_bus_mar    (sel[1]),
    .cpu_bus_mdr    (sel[0]),
    .cpu_byte_taken (taken),
    .cpu_halt       (halt),
    .rx_ready       (rx_ready),
    .data_ready     (data_ready),
    .rsp_byte       (rsp_byte),
    .proto_err      (proto_err),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends both address bytes; returns with the DUT in the TX_LO cycle.
  task automatic start_read(input logic [2:0] s, input logic [15:0] a);
    sel = s; bus = a[7:0];
    tick();
    bus = a[15:8];
    tick();
    sel = 3'b000;
    chk("rd_lat_dr0", {15'd0, data_ready}, 16'd0);
    tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    sel = 3'b001; bus = a[7:0];
    tick();
    bus = a[15:8];
    tick();
    bus = d[7:0];
    tick();
    bus = d[15:8];
    tick();
    sel = 3'b000;
  endtask

  initial begin
    rst = 1'b1; bus = 8'h00; sel = 3'b000; taken = 1'b0; halt = 1'b0;
    tick();
    tick();
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    chk("rst_data_ready", {15'd0, data_ready}, 16'd0);
    chk("rst_rsp_byte", {8'd0, rsp_byte}, 16'h0000);
    chk("rst_proto_err", {15'd0, proto_err}, 16'd0);
    chk("rst_timeout", {15'd0, timeout}, 16'd0);
    rst = 1'b0;
    tick();

    // Write 0xBEEF to 0x0012; S_WRITE holds rx_ready low for one cycle
    do_write(16'h0012, 16'hBEEF);
    chk("wr_rx_low", {15'd0, rx_ready}, 16'd0);
    tick();
    chk("wr_rx_back", {15'd0, rx_ready}, 16'd1);

    // Read 0x0012 back
    start_read(3'b010, 16'h0012);
    chk("rd_dr", {15'd0, data_ready}, 16'd1);
    chk("rd_lo", {8'd0, rsp_byte}, 16'h00EF);
    taken = 1'b1;
    tick();
    chk("rd_hi", {8'd0, rsp_byte}, 16'h00BE);
    tick();
    taken = 1'b0;
    chk("rd_done_dr", {15'd0, data_ready}, 16'd0);
    chk("rd_done_rx", {15'd0, rx_ready}, 16'd1);

    // Fetch 0x0112 wraps to 0x12
    start_read(3'b100, 16'h0112);
    chk("fetch_lo", {8'd0, rsp_byte}, 16'h00EF);
    taken = 1'b1;
    tick();
    chk("fetch_hi", {8'd0, rsp_byte}, 16'h00BE);
    tick();
    taken = 1'b0;

    // Select changes mid-transfer; a stray take while idle must be ignored
    sel = 3'b010; bus = 8'h12;
    tick();
    sel = 3'b001; bus = 8'h00; taken = 1'b1;
    tick();
    sel = 3'b000;
    chk("perr_set", {15'd0, proto_err}, 16'd1);
    chk("perr_idle_rx", {15'd0, rx_ready}, 16'd1);
    tick();
    tick();
    taken = 1'b0;
    chk("perr_no_dr", {15'd0, data_ready}, 16'd0);

    // Read with the CPU withholding the take for 5 cycles
    start_read(3'b010, 16'h0012);
    for (int i = 0; i < 5; i++) begin
      chk("hold_dr", {15'd0, data_ready}, 16'd1);
      chk("hold_lo", {8'd0, rsp_byte}, 16'h00EF);
      tick();
    end
    taken = 1'b1;
    tick();
    tick();
    taken = 1'b0;

    // Reset while in S_TX_HI
    start_read(3'b010, 16'h0012);
    taken = 1'b1;
    tick();
    taken = 1'b0;
    chk("txhi_byte", {8'd0, rsp_byte}, 16'h00BE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_dr", {15'd0, data_ready}, 16'd0);
    chk("rst_mid_rx", {15'd0, rx_ready}, 16'd1);
    chk("rst_mid_perr", {15'd0, proto_err}, 16'd0);

    // Halt during S_WRITE blocks the commit
    do_write(16'h0012, 16'h5555);
    halt = 1'b1;
    tick();
    chk("halt_rx", {15'd0, rx_ready}, 16'd0);
    halt = 1'b0;
    tick();
    tick();
    start_read(3'b010, 16'h0012);
    chk("halt_nowr_lo", {8'd0, rsp_byte}, 16'h00EF);

    // Halt during TX drops the response
    halt = 1'b1;
    tick();
    chk("halt_tx_dr", {15'd0, data_ready}, 16'd0);
    halt = 1'b0;
    tick();
    tick();
    chk("halt_rel_rx", {15'd0, rx_ready}, 16'd1);

    // Unacknowledged response
    start_read(3'b010, 16'h0012);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("tmo_pre_dr", {15'd0, data_ready}, 16'd1);
    tick();
`ifdef RESP_TIMEOUT_EN
    chk("tmo_dr", {15'd0, data_ready}, 16'd0);
    chk("tmo_flag", {15'd0, timeout}, 16'd1);
    chk("tmo_rx", {15'd0, rx_ready}, 16'd1);
`else
    chk("notmo_dr", {15'd0, data_ready}, 16'd1);
    chk("notmo_flag", {15'd0, timeout}, 16'd0);
    chk("notmo_lo", {8'd0, rsp_byte}, 16'h00EF);
    taken = 1'b1;
    tick();
    tick();
    taken = 1'b0;
    chk("notmo_end_rx", {15'd0, rx_ready}, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
